// File: rtl/fft_pkg.sv
// Shared FFT datapath types and helpers.
// complex_t is the sample bundle passed between FFT stages.
package fft_pkg;

  localparam int DATA_W = 16;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } complex_t;

  typedef enum logic {
    RD_IDLE,
    RD_DRAIN
  } rd_state_t;

  function automatic logic [31:0] bitrev(
    input logic [31:0] value,
    input int          width
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) r[i] = value[width-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/reorder_bank.sv
// Simple dual-port sample RAM: one write port,
// one synchronous read port, contents never reset.
module reorder_bank
  import fft_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  complex_t      wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output complex_t      rd_data
);

  complex_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bitrev_reorder.sv
// Ping-pong reorder buffer: restores natural order
// from the bit-reversed output of the last FFT stage.
module bitrev_reorder
  import fft_pkg::*;
#(
  parameter  int FFT_SIZE = 16,
  localparam int ADDR_W   = $clog2(FFT_SIZE)
) (
  input  logic     clk,
  input  logic     rst_n,
  input  complex_t din,
  input  logic     din_valid,
  output complex_t dout,
  output logic     dout_valid,
  output logic     dout_first,
  output logic     dout_last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FFT_SIZE - 1);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] wr_cnt;
  logic [ADDR_W-1:0] rd_cnt;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  rd_state_t         state;
  rd_state_t         state_nx;

  logic     wr_done;
  logic     rd_en;
  logic     rd_done;
  logic     rd_valid;
  logic     rd_first;
  logic     rd_last;
  complex_t rd_data;

  assign wr_addr = ADDR_W'(bitrev(32'(wr_cnt), ADDR_W));
  assign wr_done = din_valid && (wr_cnt == LAST);
  // Read of word 0 issues on the same edge IDLE sees full.
  assign rd_en   = (state == RD_DRAIN) || full[rd_bank];
  assign rd_done = rd_en && (rd_cnt == LAST);

  reorder_bank #(
    .DEPTH(2 * FFT_SIZE),
    .AW   (ADDR_W + 1)
  ) u_bank (
    .clk    (clk),
    .wr_en  (din_valid),
    .wr_addr({wr_bank, wr_addr}),
    .wr_data(din),
    .rd_en  (rd_en),
    .rd_addr({rd_bank, rd_cnt}),
    .rd_data(rd_data)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      RD_IDLE: begin
        if (full[rd_bank]) state_nx = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (rd_done) begin
          if (full[~rd_bank] ||
              (wr_done && (wr_bank != rd_bank)))
            state_nx = RD_DRAIN;
          else
            state_nx = RD_IDLE;
        end
      end
      default: state_nx = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (din_valid) begin
      wr_cnt <= wr_cnt + ONE;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RD_IDLE;
      rd_cnt   <= '0;
      rd_bank  <= 1'b0;
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      state    <= state_nx;
      rd_valid <= rd_en;
      rd_first <= rd_en && (rd_cnt == '0);
      rd_last  <= rd_done;
      if (rd_en) begin
        rd_cnt <= rd_cnt + ONE;
        if (rd_done) rd_bank <= ~rd_bank;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_first <= 1'b0;
      dout_last  <= 1'b0;
    end else begin
      dout_valid <= rd_valid;
      dout_first <= rd_first;
      dout_last  <= rd_last;
      if (rd_valid) dout <= rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && din_valid) assert (!full[wr_bank]);
  end

endmodule

// File: tb/tb_bitrev_reorder.sv
// Bench for bitrev_reorder: scoreboard on natural-order
// output, table of single frames, corner sequences.
module tb_bitrev_reorder;
  import fft_pkg::*;

  localparam int N = 16;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  complex_t din, dout;
  logic din_valid, dout_valid, dout_first, dout_last;

  complex_t din8, dout8, din64, dout64;
  logic v8, ov8, of8, ol8;
  logic v64, ov64, of64, ol64;

  bitrev_reorder #(.FFT_SIZE(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .din(din), .din_valid(din_valid),
    .dout(dout), .dout_valid(dout_valid),
    .dout_first(dout_first), .dout_last(dout_last)
  );

  bitrev_reorder #(.FFT_SIZE(8)) u8 (
    .clk(clk), .rst_n(rst_n),
    .din(din8), .din_valid(v8),
    .dout(dout8), .dout_valid(ov8),
    .dout_first(of8), .dout_last(ol8)
  );

  bitrev_reorder #(.FFT_SIZE(64)) u64 (
    .clk(clk), .rst_n(rst_n),
    .din(din64), .din_valid(v64),
    .dout(dout64), .dout_valid(ov64),
    .dout_first(of64), .dout_last(ol64)
  );

  typedef struct {
    complex_t d;
    logic     first;
    logic     last;
  } exp_t;

  typedef struct {
    int base;
    int gap_a;
    int gap_b;
    int gap_len;
    int exp_lat;
    int exp_run;
  } vec_t;

  exp_t     q[$];
  complex_t q8[$];
  complex_t q64[$];
  exp_t     mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;
  int run_len  = 0;
  int last_run = 0;
  int out_cnt  = 0;
  int first_edge = -1;
  int last_edge  = -1;
  int k8  = 0;
  int k64 = 0;

  always @(posedge clk) edge_cnt++;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      run_len = 0;
    end else if (dout_valid) begin
      run_len++;
      out_cnt++;
      if (dout_first) first_edge = edge_cnt;
      if (q.size() == 0) begin
        check("unexpected_out", dout_valid, 1'b0);
      end else begin
        mon_e = q.pop_front();
        check("dout", dout, mon_e.d);
        check("dout_first", dout_first, mon_e.first);
        check("dout_last", dout_last, mon_e.last);
      end
    end else if (run_len != 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && ov8) begin
      if (q8.size() == 0)
        check("u8_unexpected", ov8, 1'b0);
      else
        check("u8_dout", dout8, q8.pop_front());
      check("u8_first", of8, k8 == 0);
      check("u8_last", ol8, k8 == 7);
      k8 = (k8 + 1) % 8;
    end
    if (rst_n && ov64) begin
      if (q64.size() == 0)
        check("u64_unexpected", ov64, 1'b0);
      else
        check("u64_dout", dout64, q64.pop_front());
      check("u64_first", of64, k64 == 0);
      check("u64_last", ol64, k64 == 63);
      k64 = (k64 + 1) % 64;
    end
  end

  task automatic send_frame(input int base,
                            input int gap_a,
                            input int gap_b,
                            input int gap_len);
    exp_t e;
    int   v;
    for (int k = 0; k < N; k++) begin
      e.d.re  = 16'(base + k);
      e.d.im  = 16'(~(base + k));
      e.first = (k == 0);
      e.last  = (k == N - 1);
      q.push_back(e);
    end
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      v = base + int'(bitrev(i, W));
      din.re    = 16'(v);
      din.im    = 16'(~v);
      din_valid = 1'b1;
      if (i == N - 1) last_edge = edge_cnt + 1;
      if (i == gap_a || i == gap_b) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          din_valid = 1'b0;
        end
      end
    end
  endtask

  task automatic idle_in();
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int c;
    for (c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (q.size() == 0 && !dout_valid) break;
    end
    if (c == 300) check(name, 1'b1, 1'b0);
  endtask

  task automatic send_rand(input int sz, input int nf);
    complex_t arr[64];
    int       aw;
    aw = (sz == 8) ? 3 : 6;
    for (int f = 0; f < nf; f++) begin
      for (int i = 0; i < sz; i++) begin
        arr[i].re = 16'($urandom);
        arr[i].im = 16'($urandom);
      end
      for (int k = 0; k < sz; k++) begin
        if (sz == 8) q8.push_back(arr[bitrev(k, aw)]);
        else q64.push_back(arr[bitrev(k, aw)]);
      end
      for (int i = 0; i < sz; i++) begin
        @(negedge clk);
        if (sz == 8) begin
          v8 = 1'b0;
        end else begin
          v64 = 1'b0;
        end
        if ($urandom_range(0, 3) == 0) @(negedge clk);
        if (sz == 8) begin
          din8 = arr[i];
          v8   = 1'b1;
        end else begin
          din64 = arr[i];
          v64   = 1'b1;
        end
      end
    end
    @(negedge clk);
    v8  = 1'b0;
    v64 = 1'b0;
  endtask

  vec_t tbl[4];
  int   out0;
  int   c;

  initial begin
    tbl[0] = '{0,   -1, -1, 0, 2, 16};
    tbl[1] = '{100,  5, 11, 3, 2, 16};
    tbl[2] = '{200,  0, 14, 1, 2, 16};
    tbl[3] = '{300,  7, -1, 5, 2, 16};

    din = '0; din_valid = 1'b0;
    din8 = '0; v8 = 1'b0;
    din64 = '0; v64 = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_dout", dout, 32'h0);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_first", dout_first, 1'b0);
    check("rst_last", dout_last, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      first_edge = -1;
      send_frame(tbl[r].base, tbl[r].gap_a,
                 tbl[r].gap_b, tbl[r].gap_len);
      idle_in();
      wait_idle("frame_timeout");
      check("latency", first_edge - last_edge,
            tbl[r].exp_lat);
      check("run_len", last_run, tbl[r].exp_run);
    end

    for (int f = 0; f < 4; f++) send_frame(16 * f, -1, -1, 0);
    idle_in();
    wait_idle("b2b_timeout");
    check("b2b_run_len", last_run, 64);

    out0 = out_cnt;
    send_frame(500, -1, -1, 0);
    idle_in();
    for (c = 0; c < 100 && out_cnt < out0 + 8; c++) begin
      @(negedge clk);
      #1;
    end
    check("reach_idx7", out_cnt - out0, 8);
    check("idx7_valid", dout_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 32'h0);
    check("mid_rst_valid", dout_valid, 1'b0);
    check("mid_rst_first", dout_first, 1'b0);
    check("mid_rst_last", dout_last, 1'b0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    first_edge = -1;
    send_frame(0, -1, -1, 0);
    idle_in();
    wait_idle("post_rst_timeout");
    check("post_rst_run", last_run, 16);
    check("post_rst_lat", first_edge - last_edge, 2);

    send_rand(8, 3);
    send_rand(64, 2);
    for (c = 0; c < 400; c++) begin
      @(negedge clk);
      #1;
      if (q8.size() == 0 && q64.size() == 0 &&
          !ov8 && !ov64) break;
    end
    check("sweep_q8_empty", q8.size(), 0);
    check("sweep_q64_empty", q64.size(), 0);
    check("q_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitrev_reorder.md
Name: bitrev_reorder

Overview:
- Output reorder buffer placed directly downstream of the final FFT stage (NUM_STAGE == log2(FFT_SIZE)).
- The last stage emits each frame in bit-reversed index order; this block restores natural order (X[0], X[1] … X[N-1]).
- It uses a ping-pong pair of FFT_SIZE-deep banks: one bank fills while the other drains, so continuous frames stream with no gaps and no stalls.

Parameters:
- FFT_SIZE, 16, points per frame; power of two, ≥4.
- ADDR_W, $clog2(FFT_SIZE), derived bank address width; not overridden.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- din, input, complex_t, sample from the final stage, bit-reversed order.
- din_valid, input, 1, din qualifier; high for the FFT_SIZE samples of each frame, gaps allowed.
- dout, output, complex_t, sample in natural order.
- dout_valid, output, 1, dout qualifier.
- dout_first, output, 1, high with dout_valid on X[0] of each frame.
- dout_last, output, 1, high with dout_valid on X[FFT_SIZE-1] of each frame.

Behaviour:
- Reset: asynchronous assert of rst_n sets dout=0, dout_valid=0, dout_first=0, dout_last=0.
  - wr_cnt=0, wr_bank=0, rd_cnt=0, rd_bank=0, full[1:0]=0, reader idle.
  - Bank RAM contents are not reset.
- Write side:
  - On each edge with din_valid=1: write din to bank wr_bank at address bitrev(wr_cnt), then wr_cnt += 1.
  - bitrev reverses the ADDR_W bits of the count.
  - When wr_cnt == FFT_SIZE-1 at a write: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0.
  - din_valid=0 mid-frame: wr_cnt holds and the partial frame resumes on the next valid. There is no timeout.
- Read side, state machine with states IDLE and DRAIN:
  - IDLE → DRAIN when full[rd_bank]=1; rd_cnt=0.
  - In DRAIN, issue a synchronous read of bank rd_bank at address rd_cnt every cycle, then rd_cnt += 1.
  - At rd_cnt == FFT_SIZE-1: clear full[rd_bank] and toggle rd_bank.
    - If full on the other bank is already 1 (or sets on this same edge), stay in DRAIN with rd_cnt=0, giving back-to-back frames.
    - Otherwise go to IDLE.
  - dout, dout_valid, dout_first and dout_last are registered one cycle after the RAM read, so read-to-output latency is 2 cycles.
- Latency:
  - Last input sample of a frame accepted at edge t: full is set at t, the read issues at t+1, and dout_valid with X[0] appears after edge t+2.
  - With gap-free input, first input at cycle 0 gives first output at cycle FFT_SIZE+1.
  - Output is always FFT_SIZE contiguous valid cycles per frame.
- Simultaneous set and clear of full on the same bank and edge cannot occur.
  - Argument: the writer returns to a bank no earlier than FFT_SIZE cycles after filling it, and the reader finishes it in FFT_SIZE cycles.
  - Input rate is ≤1 per cycle, so no overflow path exists.
  - Verification asserts: no write to a bank while its full=1.
- No backpressure: the consumer must accept dout every valid cycle.
- Reset mid-frame discards both partially written and partially drained frames. Output restarts with the first complete frame after reset.

Decomposition:
- fft_pkg: reuse complex_t.
- fft_pkg: add a function bitrev(value, width) so other stages and testbenches can share it.
- Sub-module reorder_bank: simple dual-port RAM, FFT_SIZE × complex_t, one write port, one synchronous read port, no reset. Instantiate it twice, or once with an {bank, addr} address.
- Counters, full flags and the FSM stay in bitrev_reorder.

Test Plan:
- Single frame, FFT_SIZE=16: feed din.re = bitrev4(i) for i=0..15 on contiguous cycles → dout.re = 0,1,…,15 starting cycle 17.
  - dout_first coincides with 0 and dout_last with 15.
  - dout_valid is high for exactly 16 cycles.
- Back-to-back 4 frames, frame f with values 16f+k in bit-reversed order → 64 contiguous natural-order outputs 0..63 with no dout_valid gap.
  - The full-flag overflow assertion never fires.
- Gapped input: same frame with din_valid low for 3 cycles after samples 5 and 11 → identical natural-order output.
  - First dout_valid arrives 2 cycles after the last sample.
- Reset mid-drain: assert rst_n low during output index 7 of frame 0 → all outputs 0 immediately (asynchronous).
  - Then a fresh frame gives a clean 0..15 sequence with correct first and last flags.
- FFT_SIZE=8 and FFT_SIZE=64 parameter sweeps with random complex data → output equals the golden natural-order permutation using bitrev().
- Frame boundary race: the second frame's last sample arrives on the same edge the reader finishes frame 1 → the reader stays in DRAIN with no bubble.
